serial_add_ctrl: RTL

- Bit-serial add/subtract sequencer that time-shares one instance of the team's 1-bit full-adder cell across a WIDTH-bit operation.
- Latches operands on a start pulse and feeds one bit pair per cycle, LSB first, through the cell.
- Holds the carry between cycles in a flop and assembles the result in a shift register.
- Reports sum, carry-out, signed overflow and zero with a busy/done handshake.
- Sits between a small control FSM (e.g. lab calculator) and the full-adder cell, trading area for latency.

---
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle between a controlling FSM and the
// bit-serial add/subtract sequencer.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit full-adder cell is reused
// across WIDTH cycles, LSB first, with the carry held in a flop between bits.

// Shared 1-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_add_ctrl_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Result shift register keeps only the upper WIDTH-1 bits; the incoming
  // cell bit completes the word in r_next, so no bit is stored and discarded.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             c_msb_in;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic cell_sum;
  logic cell_cout;
  logic accept;
  logic last;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (cell_sum),
    .co (cell_cout)
  );

  // Decode of the current bit step and of a start being taken.
  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    r_next = {cell_sum, r_sh};
    if (state_q != RUN) accept = bus.start;
    if (state_q == RUN && count == CNT_LAST) last = 1'b1;
  end

  // Next-state logic: start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.start ? RUN : IDLE;
      RUN:        if (count == CNT_LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operand load, bit-serial datapath and result publication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      count    <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1 : bus.cin;
      count <= '0;
    end else if (state_q == RUN) begin
      r_sh  <= r_next[WIDTH-1:1];
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= cell_cout;
      count <= count + CW'(1);
      if (count == CNT_MSB) c_msb_in <= cell_cout;
      if (last) begin
        sum_q  <= r_next;
        cout_q <= cell_cout;
        ovf_q  <= c_msb_in ^ cell_cout;
        zero_q <= (r_next == '0);
      end
    end
  end

  // Status and result outputs, all derived from registered state.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
    bus.zero = zero_q;
  end
endmodule
